// File: rtl/logic_reduce_unit_if.sv
// rtl/logic_reduce_unit_if.sv - operand/result stream bundle for logic_reduce_unit
//
// Purpose: groups the operand input channel and the result output channel.
// Ports:
//   in_valid/in_ready/in_data    operand channel (producer -> unit)
//   out_valid/out_ready/out_data result channel (unit -> consumer)
//   out_count                    operands consumed in the reported frame
// Modports: master = stimulus/consumer side, slave = logic_reduce_unit side.

interface logic_reduce_unit_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] out_count;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_count
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_count
   );
endinterface

// File: rtl/logic_reduce_unit.sv
// rtl/logic_reduce_unit.sv - framed bitwise OR/AND/XOR/NOR stream reducer
//
// Purpose: reduces a frame of 1..MAX_OPS operands with a bitwise operation
// selected at frame start and returns the result on a valid/ready channel.
// Optional macro: LOGIC_REDUCE_ABORT_EN adds the abort input.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, op        frame start request and operation (00 OR, 01 AND, 10 XOR, 11 NOR)
//   num_ops          operand count for the frame, latched at start
//   abort            (LOGIC_REDUCE_ABORT_EN only) drop current frame, back to IDLE
//   busy             high while a frame is in progress (ACCUM or DONE)
//   err              one-cycle pulse after a start with an illegal count
//   bus              operand/result stream channels (slave modport)

module logic_reduce_unit #(
   parameter int WIDTH   = 8,
   parameter int MAX_OPS = 16,
   localparam int CNT_W  = $clog2(MAX_OPS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [CNT_W-1:0] num_ops,
`ifdef LOGIC_REDUCE_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy,
   output logic             err,
   logic_reduce_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   localparam logic [1:0]       OP_AND  = 2'b01;
   localparam logic [1:0]       OP_XOR  = 2'b10;
   localparam logic [1:0]       OP_NOR  = 2'b11;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [1:0]       op_q, op_d;
   logic [CNT_W-1:0] num_ops_q, num_ops_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;

   logic             beat;
   logic             abort_hit;
   logic [WIDTH-1:0] acc_next;
   logic [CNT_W-1:0] count_inc;

`ifdef LOGIC_REDUCE_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   assign beat      = bus.in_valid && (state_q == ACCUM);
   assign count_inc = count_q + ONE_CNT;

   // NOR accumulates as OR; the inversion is applied only when the result is captured.
   always_comb begin
      acc_next = acc_q | bus.in_data;
      case (op_q)
         OP_AND:  acc_next = acc_q & bus.in_data;
         OP_XOR:  acc_next = acc_q ^ bus.in_data;
         default: acc_next = acc_q | bus.in_data;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      count_d     = count_q;
      op_d        = op_q;
      num_ops_d   = num_ops_q;
      err_d       = 1'b0;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if ((num_ops == '0) || (num_ops > MAX_CNT)) begin
                  err_d = 1'b1;
               end else begin
                  op_d      = op;
                  num_ops_d = num_ops;
                  count_d   = '0;
                  acc_d     = (op == OP_AND) ? '1 : '0;
                  state_d   = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (abort_hit) begin
               state_d = IDLE;
            end else if (beat) begin
               acc_d   = acc_next;
               count_d = count_inc;
               if (count_inc == num_ops_q) begin
                  // Result is captured here so out_data is a pure register in DONE.
                  state_d     = DONE;
                  out_data_d  = (op_q == OP_NOR) ? ~acc_next : acc_next;
                  out_count_d = num_ops_q;
               end
            end
         end
         DONE: begin
            if (abort_hit || bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         count_q     <= '0;
         op_q        <= '0;
         num_ops_q   <= '0;
         err_q       <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         op_q        <= op_d;
         num_ops_q   <= num_ops_d;
         err_q       <= err_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
      end
   end

   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_data  = out_data_q;
   assign bus.out_count = out_count_q;
   assign busy          = (state_q != IDLE);
   assign err           = err_q;

endmodule

// File: tb/tb_logic_reduce_unit.sv
// tb/tb_logic_reduce_unit.sv - scoreboard bench for logic_reduce_unit
//
// Purpose: drives directed and random frames, predicts each result from
// per-bit population counts and checks it when the unit presents it.
// Optional macro: LOGIC_REDUCE_ABORT_EN enables the abort scenario.

module tb_logic_reduce_unit;
   localparam int WIDTH   = 8;
   localparam int MAX_OPS = 16;
   localparam int CNT_W   = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [1:0]       op_in = '0;
   logic [CNT_W-1:0] num_in = '0;
   logic             busy;
   logic             err;
`ifdef LOGIC_REDUCE_ABORT_EN
   logic             abort = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0]       cur_ops[$];
   logic [CNT_W+WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0]       last_data = '0;
   logic [CNT_W-1:0]       last_cnt = '0;
   logic [CNT_W+WIDTH-1:0] cur_exp = '0;

   logic_reduce_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   logic_reduce_unit #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op_in),
      .num_ops (num_in),
`ifdef LOGIC_REDUCE_ABORT_EN
      .abort   (abort),
`endif
      .busy    (busy),
      .err     (err),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Per bit: OR = any one, AND = all ones, XOR = odd ones, NOR = no ones.
   function automatic logic [WIDTH-1:0] model(input logic [1:0] o);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int b = 0; b < WIDTH; b++) begin
         int ones;
         ones = 0;
         foreach (cur_ops[i]) ones += int'(cur_ops[i][b]);
         case (o)
            2'd0: r[b] = (ones > 0);
            2'd1: r[b] = (ones == cur_ops.size());
            2'd2: r[b] = (ones % 2) == 1;
            default: r[b] = (ones == 0);
         endcase
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual=%0h expected=none", bus.out_data);
         end else begin
            logic [CNT_W+WIDTH-1:0] e;
            e = exp_q.pop_front();
            check("sb_data", 32'(bus.out_data), 32'(e[WIDTH-1:0]));
            check("sb_count", 32'(bus.out_count), 32'(e[CNT_W+WIDTH-1:WIDTH]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_frame(input logic [1:0] o);
      cur_exp = {CNT_W'(cur_ops.size()), model(o)};
      exp_q.push_back(cur_exp);
      start  = 1'b1;
      op_in  = o;
      num_in = CNT_W'(cur_ops.size());
      tick();
      start  = 1'b0;
      op_in  = 2'($urandom);
      num_in = CNT_W'($urandom);
   endtask

   task automatic send_beat(input logic [WIDTH-1:0] d, input int gap);
      int t;
      bus.in_valid = 1'b0;
      repeat (gap) tick();
      t = 0;
      while (!bus.in_ready && t < 50) begin
         tick();
         t++;
      end
      if (!bus.in_ready) check("in_ready_wait", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      tick();
      bus.in_valid = 1'b0;
      bus.in_data  = WIDTH'($urandom);
   endtask

   task automatic collect(input int hold, input bit poke);
      int t;
      bus.out_ready = 1'b0;
      t = 0;
      while (!bus.out_valid && t < 50) begin
         tick();
         t++;
      end
      check("ov_wait", 32'(bus.out_valid), 32'd1);
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_data", 32'(bus.out_data), 32'(cur_exp[WIDTH-1:0]));
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
         if (poke && i == 2) begin
            start  = 1'b1;
            op_in  = 2'd0;
            num_in = CNT_W'(3);
         end
         tick();
         start = 1'b0;
         check("hold_no_err", 32'(err), 32'd0);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("ov_drop", 32'(bus.out_valid), 32'd0);
      check("busy_drop", 32'(busy), 32'd0);
      check("data_keep", 32'(bus.out_data), 32'(cur_exp[WIDTH-1:0]));
      last_data = cur_exp[WIDTH-1:0];
      last_cnt  = cur_exp[CNT_W+WIDTH-1:WIDTH];
   endtask

   task automatic bad_start(input logic [CNT_W-1:0] n);
      start  = 1'b1;
      num_in = n;
      tick();
      start = 1'b0;
      check("err_pulse", 32'(err), 32'd1);
      check("err_busy", 32'(busy), 32'd0);
      check("err_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check("err_clear", 32'(err), 32'd0);
      check("err_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_out_count", 32'(bus.out_count), 32'd0);
      rst_n = 1'b1;
      tick();

      // OR, back-to-back beats, immediate acceptance
      cur_ops = '{8'h01, 8'h10, 8'h80};
      begin_frame(2'd0);
      check("accum_busy", 32'(busy), 32'd1);
      foreach (cur_ops[i]) send_beat(cur_ops[i], 0);
      check("latency_valid", 32'(bus.out_valid), 32'd1);
      check("or_data", 32'(bus.out_data), 32'h91);
      check("or_count", 32'(bus.out_count), 32'd3);
      collect(0, 1'b0);

      // AND with a 2-cycle gap, then XOR
      cur_ops = '{8'hF0, 8'h3C};
      begin_frame(2'd1);
      send_beat(8'hF0, 0);
      send_beat(8'h3C, 2);
      check("and_data", 32'(bus.out_data), 32'h30);
      collect(0, 1'b0);
      cur_ops = '{8'hFF, 8'h0F, 8'h01};
      begin_frame(2'd2);
      foreach (cur_ops[i]) send_beat(cur_ops[i], 0);
      check("xor_data", 32'(bus.out_data), 32'hF1);
      collect(0, 1'b0);

      // Illegal counts
      bad_start(CNT_W'(0));
      bad_start(CNT_W'(17));

      // NOR single beat with back-pressure and an ignored start
      cur_ops = '{8'h00};
      begin_frame(2'd3);
      send_beat(8'h00, 0);
      check("nor1_data", 32'(bus.out_data), 32'hFF);
      collect(5, 1'b1);
      tick();
      check("poke_ignored", 32'(busy), 32'd0);

      // NOR over a full MAX_OPS frame
      cur_ops.delete();
      for (int i = 0; i < MAX_OPS; i++) cur_ops.push_back(8'h00);
      begin_frame(2'd3);
      foreach (cur_ops[i]) send_beat(cur_ops[i], 0);
      check("nor16_data", 32'(bus.out_data), 32'hFF);
      check("nor16_count", 32'(bus.out_count), 32'd16);
      collect(0, 1'b0);

      // Asynchronous reset mid-frame
      cur_ops = '{8'h01, 8'h02, 8'h04, 8'h08};
      begin_frame(2'd0);
      send_beat(8'h01, 0);
      send_beat(8'h02, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_in_ready", 32'(bus.in_ready), 32'd0);
      check("arst_out_valid", 32'(bus.out_valid), 32'd0);
      check("arst_out_data", 32'(bus.out_data), 32'd0);
      check("arst_out_count", 32'(bus.out_count), 32'd0);
      exp_q.delete();
      last_data = '0;
      last_cnt  = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      cur_ops = '{8'h21, 8'h42, 8'h04, 8'h80};
      begin_frame(2'd0);
      foreach (cur_ops[i]) send_beat(cur_ops[i], 0);
      check("post_rst_data", 32'(bus.out_data), 32'hE7);
      collect(1, 1'b0);

`ifdef LOGIC_REDUCE_ABORT_EN
      cur_ops = '{8'h11, 8'h22, 8'h44, 8'h88};
      begin_frame(2'd2);
      send_beat(8'h11, 0);
      send_beat(8'h22, 0);
      abort = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h44;
      tick();
      abort = 1'b0;
      bus.in_valid = 1'b0;
      exp_q.delete();
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_err", 32'(err), 32'd0);
      check("abort_data", 32'(bus.out_data), 32'(last_data));
      check("abort_count", 32'(bus.out_count), 32'(last_cnt));
      for (int i = 0; i < 3; i++) begin
         check("abort_no_valid", 32'(bus.out_valid), 32'd0);
         tick();
      end
`endif

      // Random frames
      for (int f = 0; f < 24; f++) begin
         logic [1:0] o;
         int n;
         o = 2'($urandom);
         n = $urandom_range(1, MAX_OPS);
         cur_ops.delete();
         for (int i = 0; i < n; i++) cur_ops.push_back(WIDTH'($urandom));
         begin_frame(o);
         foreach (cur_ops[i]) send_beat(cur_ops[i], $urandom_range(0, 2));
         collect($urandom_range(0, 3), 1'b0);
      end

      repeat (3) tick();
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
